coord_entry_fsm: RTL and testbench

Parametrised coordinate-entry controller for the board's alpha display path. The user steps a row/column cursor with buttons and pushes up to DEPTH coordinates into an internal buffer. In DISPLAY the block replays the stored coordinates one per `beat`, feeding the external character-lookup/SSD stage. It succeeds the fixed 3-bit single-coordinate FSM and adds configurable width and limits, up/down stepping, internal edge detection, and a multi-entry buffer with replay.

---
 rtl/coord_entry_fsm_if.sv | 38 +++
 rtl/coord_entry_fsm.sv | 162 ++++++++++++++++
 tb/tb_coord_entry_fsm.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/coord_entry_fsm_if.sv
// Button, replay-strobe and display-side signals of the coordinate-entry controller.
// Latency: none (wires only).
// Backpressure: none; buttons are levels and beat is a single-cycle strobe.
interface coord_entry_fsm_if #(
    parameter int COORD_W = 3,
    parameter int CNT_W   = 3
);
    logic               enter;
    logic               r_btn;
    logic               c_btn;
    logic               dir;
    logic               push;
    logic               beat;
    logic [1:0]         state_o;
    logic [COORD_W-1:0] row_cur;
    logic [COORD_W-1:0] col_cur;
    logic [COORD_W-1:0] row_out;
    logic [COORD_W-1:0] col_out;
    logic               out_valid;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               overflow;

    // Button / beat source side (board inputs, or the bench).
    modport master (
        output enter, r_btn, c_btn, dir, push, beat,
        input  state_o, row_cur, col_cur, row_out, col_out,
        input  out_valid, count, full, empty, overflow
    );

    // Controller side.
    modport slave (
        input  enter, r_btn, c_btn, dir, push, beat,
        output state_o, row_cur, col_cur, row_out, col_out,
        output out_valid, count, full, empty, overflow
    );
endinterface

// File: rtl/coord_entry_fsm.sv
// Coordinate-entry controller: cursor stepping, multi-entry buffer, beat-paced replay.
// Latency: a button edge or beat at clock t takes effect at t+1; full/empty decode count directly.
// Backpressure: none; a push while full is dropped and latches the sticky overflow flag.
module coord_entry_fsm #(
    parameter int COORD_W = 3,
    parameter int ROW_MAX = 7,
    parameter int COL_MAX = 7,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    coord_entry_fsm_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [COORD_W-1:0] ROW_TOP = COORD_W'(ROW_MAX);
    localparam logic [COORD_W-1:0] COL_TOP = COORD_W'(COL_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        INPUT   = 2'b01,
        DISPLAY = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic enter_q, r_btn_q, c_btn_q, push_q;
    logic enter_e, r_e, c_e, push_e;

    logic [COORD_W-1:0] row_q, col_q, row_step, col_step;
    logic [COORD_W-1:0] row_out_q, col_out_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               overflow_q;
    logic               full_w, rd_last, do_push, do_beat;

    logic [2*COORD_W-1:0] mem [DEPTH];

    // Edge detection: an edge is a high level whose previous sample was low.
    assign enter_e = bus.enter & ~enter_q;
    assign r_e     = bus.r_btn & ~r_btn_q;
    assign c_e     = bus.c_btn & ~c_btn_q;
    assign push_e  = bus.push  & ~push_q;

    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign rd_last = ((CNT_W'(rd_ptr) + CNT_W'(1)) == count_q);
    // Push stores the cursor as it was before any same-cycle step.
    assign do_push = (state == INPUT) & push_e & ~full_w;
    // An enter edge wins over a coincident beat: the beat is discarded.
    assign do_beat = (state == DISPLAY) & bus.beat & ~enter_e;

    // Wrapping up/down step for both cursor axes.
    always_comb begin
        row_step = row_q;
        col_step = col_q;
        if (bus.dir) begin
            row_step = (row_q == '0) ? ROW_TOP : row_q - COORD_W'(1);
            col_step = (col_q == '0) ? COL_TOP : col_q - COORD_W'(1);
        end else begin
            row_step = (row_q == ROW_TOP) ? '0 : row_q + COORD_W'(1);
            col_step = (col_q == COL_TOP) ? '0 : col_q + COORD_W'(1);
        end
    end

    // Next-state: every state advances on an enter edge; the unused encoding recovers to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enter_e) state_nxt = INPUT;
            INPUT:   if (enter_e) state_nxt = DISPLAY;
            DISPLAY: if (enter_e) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, button history, cursor, counters and replay outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            enter_q     <= 1'b0;
            r_btn_q     <= 1'b0;
            c_btn_q     <= 1'b0;
            push_q      <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            row_out_q   <= '0;
            col_out_q   <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            enter_q <= bus.enter;
            r_btn_q <= bus.r_btn;
            c_btn_q <= bus.c_btn;
            push_q  <= bus.push;
            case (state)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    // Starting a new entry session discards the old buffer logically.
                    if (enter_e) begin
                        row_q      <= '0;
                        col_q      <= '0;
                        count_q    <= '0;
                        wr_ptr     <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                INPUT: begin
                    if (r_e) row_q <= row_step;
                    if (c_e) col_q <= col_step;
                    if (push_e) begin
                        if (full_w) begin
                            overflow_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                            wr_ptr  <= wr_ptr + PTR_W'(1);
                        end
                    end
                    if (enter_e) begin
                        rd_ptr      <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                DISPLAY: begin
                    if (enter_e) begin
                        out_valid_q <= 1'b0;
                    end else if (do_beat) begin
                        out_valid_q <= 1'b1;
                        if (count_q == '0) begin
                            row_out_q <= row_q;
                            col_out_q <= col_q;
                        end else begin
                            {row_out_q, col_out_q} <= mem[rd_ptr];
                            rd_ptr <= rd_last ? '0 : rd_ptr + PTR_W'(1);
                        end
                    end
                end
                default: out_valid_q <= 1'b0;
            endcase
        end
    end

    // Entry buffer; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= {row_q, col_q};
    end

    assign bus.state_o   = state;
    assign bus.row_cur   = row_q;
    assign bus.col_cur   = col_q;
    assign bus.row_out   = row_out_q;
    assign bus.col_out   = col_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = count_q;
    assign bus.full      = full_w;
    assign bus.empty     = (count_q == '0);
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_coord_entry_fsm.sv
// Bench for coord_entry_fsm: reference model of cursor/buffer, scoreboard of replay outputs.
// Latency: inputs driven and outputs sampled on the falling edge, one rising edge apart.
// Backpressure: none; each expected replay value is queued at its beat and popped one cycle later.
module tb_coord_entry_fsm;
    localparam int W       = 3;
    localparam int ROW_MAX = 5;
    localparam int COL_MAX = 7;
    localparam int DEPTH   = 4;
    localparam int CW      = 3;

    logic clk = 1'b0;
    logic reset;

    coord_entry_fsm_if #(.COORD_W(W), .CNT_W(CW)) bus ();

    coord_entry_fsm #(
        .COORD_W(W), .ROW_MAX(ROW_MAX), .COL_MAX(COL_MAX), .DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model.
    logic [1:0]       m_state;
    logic [W-1:0]     m_row, m_col;
    logic [2*W-1:0]   m_buf[$];
    logic             m_ovf;
    int               m_rd;
    logic [2*W-1:0]   m_last;
    logic [2*W-1:0]   exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_clear();
        m_row = '0;
        m_col = '0;
        m_buf.delete();
        m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        m_state = 2'b00;
        model_clear();
        m_rd   = 0;
        m_last = '0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".state"}, bus.state_o, m_state);
        chk({tag, ".row"},   bus.row_cur, m_row);
        chk({tag, ".col"},   bus.col_cur, m_col);
        chk({tag, ".count"}, bus.count,   m_buf.size());
        chk({tag, ".full"},  bus.full,    m_buf.size() == DEPTH);
        chk({tag, ".empty"}, bus.empty,   m_buf.size() == 0);
        chk({tag, ".ovf"},   bus.overflow, m_ovf);
    endtask

    // m: bit0 enter, bit1 r_btn, bit2 c_btn, bit3 push; one-cycle press then release.
    task automatic press(input logic [3:0] m);
        if (m_state == 2'b01) begin
            if (m[3]) begin
                if (m_buf.size() < DEPTH) m_buf.push_back({m_row, m_col});
                else                      m_ovf = 1'b1;
            end
            if (m[1]) m_row = bus.dir ? ((m_row == 0) ? W'(ROW_MAX) : m_row - W'(1))
                                      : ((m_row == W'(ROW_MAX)) ? '0 : m_row + W'(1));
            if (m[2]) m_col = bus.dir ? ((m_col == 0) ? W'(COL_MAX) : m_col - W'(1))
                                      : ((m_col == W'(COL_MAX)) ? '0 : m_col + W'(1));
        end
        if (m[0]) begin
            case (m_state)
                2'b00:   begin m_state = 2'b01; model_clear(); end
                2'b01:   begin m_state = 2'b11; m_rd = 0; end
                default: m_state = 2'b00;
            endcase
        end
        bus.enter = m[0];
        bus.r_btn = m[1];
        bus.c_btn = m[2];
        bus.push  = m[3];
        step();
        bus.enter = 1'b0;
        bus.r_btn = 1'b0;
        bus.c_btn = 1'b0;
        bus.push  = 1'b0;
        step();
    endtask

    task automatic beat_once(input logic with_enter);
        logic [2*W-1:0] e, got;
        if (with_enter) begin
            m_state = 2'b00;
        end else begin
            if (m_buf.size() > 0) begin
                e = m_buf[m_rd];
                m_rd = (m_rd + 1) % m_buf.size();
            end else begin
                e = {m_row, m_col};
            end
            exp_q.push_back(e);
            m_last = e;
        end
        bus.beat  = 1'b1;
        bus.enter = with_enter;
        step();
        bus.beat  = 1'b0;
        bus.enter = 1'b0;
        if (!with_enter) begin
            chk("beat.vld", bus.out_valid, 1'b1);
            chk("sb.depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                got = {bus.row_out, bus.col_out};
                chk("replay", got, exp_q.pop_front());
            end
        end
        step();
    endtask

    initial begin
        bus.enter = 1'b0;
        bus.r_btn = 1'b0;
        bus.c_btn = 1'b0;
        bus.dir   = 1'b0;
        bus.push  = 1'b0;
        bus.beat  = 1'b0;
        do_reset();
        check_model("rst");
        chk("rst.vld",  bus.out_valid, 1'b0);
        chk("rst.rout", bus.row_out, 0);
        chk("rst.cout", bus.col_out, 0);

        press(4'b0001);
        check_model("enter1");

        // Enter held through reset yields exactly one edge afterwards.
        reset = 1'b1;
        bus.enter = 1'b1;
        step();
        step();
        chk("hold.rst_state", bus.state_o, 2'b00);
        reset = 1'b0;
        m_state = 2'b00;
        model_clear();
        m_state = 2'b01;
        step();
        chk("hold.state1", bus.state_o, 2'b01);
        step();
        chk("hold.state2", bus.state_o, 2'b01);
        bus.enter = 1'b0;
        step();
        check_model("hold");

        // Row wrap upward then downward across ROW_MAX.
        bus.dir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            press(4'b0010);
            chk("row.up", bus.row_cur, (i + 1) % (ROW_MAX + 1));
        end
        bus.dir = 1'b1;
        press(4'b0010);
        chk("row.down_wrap", bus.row_cur, ROW_MAX);

        // Move to 2/3, then step both axes and push in one cycle.
        for (int i = 0; i < 3; i++) press(4'b0010);
        bus.dir = 1'b0;
        for (int i = 0; i < 3; i++) press(4'b0100);
        check_model("pos23");
        press(4'b1110);
        check_model("rcpush");

        // Fill to DEPTH, then one extra push at a distinct cursor.
        press(4'b1000);
        press(4'b0010);
        press(4'b1000);
        press(4'b0100);
        press(4'b1000);
        press(4'b0010);
        press(4'b1000);
        check_model("full");
        press(4'b0001);
        check_model("disp1");
        for (int i = 0; i < 5; i++) beat_once(1'b0);

        press(4'b0001);
        check_model("idle1");
        chk("idle1.vld",  bus.out_valid, 1'b0);
        chk("idle1.hold", {bus.row_out, bus.col_out}, m_last);
        press(4'b0001);
        check_model("input2");

        // Store (1,1),(2,2),(3,3); the last push coincides with enter.
        press(4'b0110);
        press(4'b1110);
        press(4'b1110);
        press(4'b1001);
        check_model("disp2");
        for (int i = 0; i < 4; i++) beat_once(1'b0);

        press(4'b0001);
        press(4'b0001);
        check_model("input3");
        for (int i = 0; i < 4; i++) press(4'b0110);
        press(4'b0100);
        press(4'b0100);
        press(4'b0001);
        check_model("disp3");
        beat_once(1'b0);
        beat_once(1'b1);
        check_model("idle3");
        chk("idle3.vld",  bus.out_valid, 1'b0);
        chk("idle3.hold", {bus.row_out, bus.col_out}, m_last);
        press(4'b0001);
        check_model("input4");

        // Reset mid-session restores everything.
        press(4'b1110);
        press(4'b1000);
        check_model("pre_rst");
        do_reset();
        check_model("mid_rst");
        chk("mid_rst.vld",  bus.out_valid, 1'b0);
        chk("mid_rst.rout", {bus.row_out, bus.col_out}, 0);

        chk("sb.drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
